// File: rtl/memctrl_pkg.sv
// Shared constants for the memory controller: FSM state encoding, port ids,
// latency-counter width and the round-robin grant helper.
package memctrl_pkg;

    // Width of the latency down-counter; LATENCY may range from 1 to 15.
    localparam int COUNT_WIDTH = 4;

    // Controller state encoding.
    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    // Initiator ids, also used for the round-robin history.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Picks the port to serve from the current requests. A lone requester
    // always wins, and on a tie the port that was not served last wins.
    function automatic logic pickPort(input logic lastGrant, input logic iReq, input logic dReq);
        if (iReq && dReq) begin
            return (lastGrant == PORT_D) ? PORT_I : PORT_D;
        end else if (dReq) begin
            return PORT_D;
        end else begin
            return PORT_I;
        end
    endfunction

endpackage

// File: rtl/memctrl_ram.sv
// Single-port 32-bit word RAM with synchronous write and registered read.
// The contents are never reset.
module memctrl_ram
    import memctrl_pkg::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // One access per enabled cycle: a write updates the array, a read
    // updates the output register, which otherwise keeps its old value.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_controller.sv
// Backing-store responder shared by the I-cache and D-cache. It arbitrates
// round-robin between the two initiators and serves one word access at a
// time from an on-chip RAM after LATENCY cycles.
// Optional feature: define MEMCTRL_INVALIDATE_EN to pulse inval_valid with
// the word-aligned address of every completed D-side write.
module memory_controller
    import memctrl_pkg::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic [31:0] i_fetch_read_data,
    output logic        i_valid,
    input  logic        d_req,
    input  logic [31:0] d_address,
    input  logic [31:0] d_write_data,
    input  logic        d_write_enable,
    output logic [31:0] d_fetch_read_data,
    output logic        d_valid,
    output logic        inval_valid,
    output logic [31:0] inval_address
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(LATENCY - 1);

    logic                   state_q,     state_d;
    logic [COUNT_WIDTH-1:0] count_q,     count_d;
    logic                   grant_q,     grant_d;
    logic                   lastGrant_q, lastGrant_d;
    logic [ADDR_WIDTH-1:0]  word_q,      word_d;
    logic [31:0]            wdata_q,     wdata_d;
    logic                   isWrite_q,   isWrite_d;
    logic                   iValid_q,    iValid_d;
    logic                   dValid_q,    dValid_d;
    logic                   dReadDone_q, dReadDone_d;
    logic [31:0]            iHold_q;
    logic [31:0]            dHold_q;
    logic                   accessNow;
    logic                   ramEn;
    logic                   ramWe;
    logic [31:0]            ramRdata;

    // Byte-offset and alias bits of both addresses play no part in decoding.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{i_address[31:ADDR_WIDTH+2], i_address[1:0],
                              d_address[31:ADDR_WIDTH+2], d_address[1:0]};

    // Next-state logic: accept and latch one request in IDLE, count down in
    // BUSY and complete the access when the counter has reached zero.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        isWrite_d   = isWrite_q;
        iValid_d    = 1'b0;
        dValid_d    = 1'b0;
        dReadDone_d = 1'b0;
        accessNow   = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (i_req || d_req) begin
                    grant_d = pickPort(lastGrant_q, i_req, d_req);
                    if (grant_d == PORT_I) begin
                        word_d    = i_address[ADDR_WIDTH+1:2];
                        isWrite_d = 1'b0;
                    end else begin
                        word_d    = d_address[ADDR_WIDTH+1:2];
                        wdata_d   = d_write_data;
                        isWrite_d = d_write_enable;
                    end
                    count_d = COUNT_LOAD;
                    state_d = STATE_BUSY;
                end
            end
            STATE_BUSY: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    accessNow   = 1'b1;
                    lastGrant_d = grant_q;
                    state_d     = STATE_IDLE;
                    if (grant_q == PORT_I) begin
                        iValid_d = 1'b1;
                    end else begin
                        dValid_d    = 1'b1;
                        dReadDone_d = !isWrite_q;
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // A reset on the completion edge aborts the access, so the RAM is gated.
    assign ramEn = accessNow && !reset;
    assign ramWe = ramEn && isWrite_q;

    memctrl_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .en_i    (ramEn),
        .we_i    (ramWe),
        .addr_i  (word_q),
        .wdata_i (wdata_q),
        .rdata_o (ramRdata)
    );

    // Controller registers with synchronous reset; last grant restarts at D
    // so the I-side wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            count_q     <= '0;
            grant_q     <= PORT_I;
            lastGrant_q <= PORT_D;
            word_q      <= '0;
            wdata_q     <= '0;
            isWrite_q   <= 1'b0;
            iValid_q    <= 1'b0;
            dValid_q    <= 1'b0;
            dReadDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            isWrite_q   <= isWrite_d;
            iValid_q    <= iValid_d;
            dValid_q    <= dValid_d;
            dReadDone_q <= dReadDone_d;
        end
    end

    // Per-port hold registers copy the shared RAM output during that port's
    // read-valid cycle so each port keeps its own data afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            iHold_q <= '0;
            dHold_q <= '0;
        end else begin
            if (iValid_q) begin
                iHold_q <= ramRdata;
            end
            if (dReadDone_q) begin
                dHold_q <= ramRdata;
            end
        end
    end

    assign i_valid           = iValid_q;
    assign d_valid           = dValid_q;
    assign i_fetch_read_data = iValid_q    ? ramRdata : iHold_q;
    assign d_fetch_read_data = dReadDone_q ? ramRdata : dHold_q;

`ifdef MEMCTRL_INVALIDATE_EN
    logic        invalValid_q;
    logic [31:0] invalAddress_q;
    logic [31:0] invalAddress_d;
    logic        invalFire;

    assign invalFire = ramWe && (grant_q == PORT_D);

    // Rebuild the word-aligned byte address from the latched word index.
    always_comb begin
        invalAddress_d                  = '0;
        invalAddress_d[ADDR_WIDTH+1:2]  = word_q;
    end

    // Pulse the invalidate alongside d_valid and hold the address until the
    // next D-side write completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            invalValid_q   <= 1'b0;
            invalAddress_q <= '0;
        end else begin
            invalValid_q <= invalFire;
            if (invalFire) begin
                invalAddress_q <= invalAddress_d;
            end
        end
    end

    assign inval_valid   = invalValid_q;
    assign inval_address = invalAddress_q;
`else
    assign inval_valid   = 1'b0;
    assign inval_address = '0;
`endif

endmodule
